// File: rtl/gray_codec_pipe.sv
// Registered binary<->Gray converter behind a valid/ready handshake with a 2-entry result buffer,
// plus an independent up/down Gray-code counter.
module gray_codec_pipe #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic             in_mode_i,
    input  logic [WIDTH-1:0] in_data_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] out_data_o,
    input  logic             cnt_en_i,
    input  logic             cnt_up_i,
    input  logic             cnt_clr_i,
    output logic [WIDTH-1:0] cnt_gray_o,
    output logic             cnt_wrap_o
);

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    function automatic logic [WIDTH-1:0] bin2gray(input logic [WIDTH-1:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [WIDTH-1:0] gray2bin(input logic [WIDTH-1:0] g);
        logic [WIDTH-1:0] b;
        b            = '0;
        b[WIDTH-1]   = g[WIDTH-1];
        for (int i = WIDTH - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    // ---------------------------------------------------------------
    // Converter with 2-entry result buffer (head_q is always the oldest)
    // ---------------------------------------------------------------
    logic [1:0]       occ_q, occ_d;
    logic [WIDTH-1:0] head_q, head_d;
    logic [WIDTH-1:0] tail_q, tail_d;
    logic [WIDTH-1:0] conv_word;
    logic             accept;
    logic             pop;

    assign in_ready_o  = (occ_q != 2'd2);
    assign out_valid_o = (occ_q != 2'd0);
    assign out_data_o  = head_q;

    assign accept    = in_valid_i & in_ready_o;
    assign pop       = out_valid_o & out_ready_i;
    assign conv_word = in_mode_i ? gray2bin(in_data_i) : bin2gray(in_data_i);

    always_comb begin
        occ_d  = occ_q;
        head_d = head_q;
        tail_d = tail_q;
        unique case ({accept, pop})
            2'b10: begin
                if (occ_q == 2'd0) head_d = conv_word;
                else               tail_d = conv_word;
                occ_d = occ_q + 2'd1;
            end
            2'b01: begin
                head_d = tail_q;
                occ_d  = occ_q - 2'd1;
            end
            2'b11: begin
                // Accept with a full buffer cannot happen, so only occupancy 1 reaches here
                // in practice; the occupancy-2 arm keeps ordering correct regardless.
                if (occ_q == 2'd2) begin
                    head_d = tail_q;
                    tail_d = conv_word;
                end else begin
                    head_d = conv_word;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occ_q  <= 2'd0;
            head_q <= '0;
            tail_q <= '0;
        end else begin
            occ_q  <= occ_d;
            head_q <= head_d;
            tail_q <= tail_d;
        end
    end

    // ---------------------------------------------------------------
    // Up/down counter: binary state, Gray output registered from next value
    // ---------------------------------------------------------------
    logic [WIDTH-1:0] cb_q, cb_d;
    logic [WIDTH-1:0] gray_q;
    logic             wrap_q, wrap_d;

    always_comb begin
        cb_d   = cb_q;
        wrap_d = 1'b0;
        if (cnt_clr_i) begin
            cb_d = '0;
        end else if (cnt_en_i) begin
            if (cnt_up_i) begin
                cb_d   = cb_q + ONE;
                wrap_d = &cb_q;
            end else begin
                cb_d   = cb_q - ONE;
                wrap_d = ~|cb_q;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cb_q   <= '0;
            gray_q <= '0;
            wrap_q <= 1'b0;
        end else begin
            cb_q   <= cb_d;
            gray_q <= bin2gray(cb_d);
            wrap_q <= wrap_d;
        end
    end

    assign cnt_gray_o = gray_q;
    assign cnt_wrap_o = wrap_q;

endmodule

// File: tb/tb_gray_codec_pipe.sv
// Directed bench for gray_codec_pipe: queue-based reference model checked every cycle,
// plus hand-computed literal expectations.
module tb_gray_codec_pipe;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic         in_mode = 1'b0;
    logic [W-1:0] in_data = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] out_data;
    logic         cnt_en = 1'b0;
    logic         cnt_up = 1'b0;
    logic         cnt_clr = 1'b0;
    logic [W-1:0] cnt_gray;
    logic         cnt_wrap;

    int n_checks = 0;
    int n_err    = 0;

    gray_codec_pipe #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .in_mode_i   (in_mode),
        .in_data_i   (in_data),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .out_data_o  (out_data),
        .cnt_en_i    (cnt_en),
        .cnt_up_i    (cnt_up),
        .cnt_clr_i   (cnt_clr),
        .cnt_gray_o  (cnt_gray),
        .cnt_wrap_o  (cnt_wrap)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference model: encode by definition, decode as XOR of all Gray bits at or above i
    function automatic logic [W-1:0] m_enc(input logic [W-1:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [W-1:0] m_dec(input logic [W-1:0] g);
        logic [W-1:0] b;
        for (int i = 0; i < W; i++) b[i] = ^(g >> i);
        return b;
    endfunction

    logic [W-1:0] mq[$];
    int           mcnt = 0;
    bit           mwrap = 1'b0;
    bit           m_acc, m_pop;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mq.delete();
            mcnt  = 0;
            mwrap = 1'b0;
        end else begin
            m_acc = in_valid && (mq.size() != 2);
            m_pop = out_ready && (mq.size() != 0);
            if (m_pop) void'(mq.pop_front());
            if (m_acc) mq.push_back(in_mode ? m_dec(in_data) : m_enc(in_data));
            if (cnt_clr) begin
                mcnt  = 0;
                mwrap = 1'b0;
            end else if (cnt_en) begin
                mwrap = cnt_up ? (mcnt == (1 << W) - 1) : (mcnt == 0);
                mcnt  = (mcnt + (cnt_up ? 1 : -1) + (1 << W)) % (1 << W);
            end else begin
                mwrap = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            chk("in_ready", in_ready, mq.size() != 2);
            chk("out_valid", out_valid, mq.size() != 0);
            if (mq.size() != 0) chk("out_data", out_data, mq[0]);
            chk("cnt_gray", cnt_gray, m_enc(W'(mcnt)));
            chk("cnt_wrap", cnt_wrap, mwrap);
        end
    end

    // Everything the consumer actually took, in order
    logic [W-1:0] cap[$];
    always @(posedge clk) begin
        if (rst_n && out_valid && out_ready) cap.push_back(out_data);
    end

    localparam logic [W-1:0] TBL [16] = '{4'b0001, 4'b0011, 4'b0010, 4'b0110,
                                          4'b0111, 4'b0101, 4'b0100, 4'b1100,
                                          4'b1101, 4'b1111, 4'b1110, 4'b1010,
                                          4'b1011, 4'b1001, 4'b1000, 4'b0000};

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    logic [W-1:0] g[16];
    logic [W-1:0] prev;

    initial begin
        #1 rst_n = 1'b0;
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_cnt_gray", cnt_gray, 0);
        chk("rst_cnt_wrap", cnt_wrap, 0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        #1 chk("rst_in_ready", in_ready, 1);

        // 1: encode 1011
        step();
        in_valid = 1'b1; in_mode = 1'b0; in_data = 4'b1011; out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        chk("t1_valid", out_valid, 1);
        chk("t1_data", out_data, 4'b1110);
        step();
        chk("t1_valid_drop", out_valid, 0);

        // 2: decode 1110, then round trip of all values
        in_valid = 1'b1; in_mode = 1'b1; in_data = 4'b1110;
        step();
        chk("t2_dec", out_data, 4'b1011);
        in_valid = 1'b0;
        step();
        cap.delete();
        for (int v = 0; v < 16; v++) begin
            in_valid = 1'b1; in_mode = 1'b0; in_data = W'(v);
            step();
            chk("t2_enc_ready", in_ready, 1);
        end
        in_valid = 1'b0;
        step();
        chk("t2_enc_count", cap.size(), 16);
        for (int v = 0; v < 16; v++) g[v] = (v < cap.size()) ? cap[v] : '0;
        cap.delete();
        for (int v = 0; v < 16; v++) begin
            in_valid = 1'b1; in_mode = 1'b1; in_data = g[v];
            step();
            chk("t2_dec_ready", in_ready, 1);
        end
        in_valid = 1'b0;
        step();
        chk("t2_dec_count", cap.size(), 16);
        for (int v = 0; v < 16; v++)
            if (v < cap.size()) chk("t2_roundtrip", cap[v], v);

        // 3: backpressure, three words
        cap.delete();
        out_ready = 1'b0;
        in_valid = 1'b1; in_mode = 1'b0; in_data = 4'd3;
        step();
        chk("t3_ready_1", in_ready, 1);
        chk("t3_head_a", out_data, 4'd2);
        in_data = 4'd5;
        step();
        chk("t3_ready_2", in_ready, 0);
        in_data = 4'd9;
        step();
        chk("t3_ready_held", in_ready, 0);
        chk("t3_head_held", out_data, 4'd2);
        out_ready = 1'b1;
        step();
        chk("t3_ready_back", in_ready, 1);
        chk("t3_head_b", out_data, 4'd7);
        step();
        chk("t3_head_c", out_data, 4'd13);
        in_valid = 1'b0;
        step();
        chk("t3_empty", out_valid, 0);
        chk("t3_count", cap.size(), 3);
        if (cap.size() == 3) begin
            chk("t3_word0", cap[0], 4'd2);
            chk("t3_word1", cap[1], 4'd7);
            chk("t3_word2", cap[2], 4'd13);
        end

        // 4: count up through a full wrap
        cnt_en = 1'b1; cnt_up = 1'b1;
        prev = cnt_gray;
        chk("t4_start", cnt_gray, 0);
        for (int i = 0; i < 16; i++) begin
            step();
            chk("t4_gray", cnt_gray, TBL[i]);
            chk("t4_wrap", cnt_wrap, i == 15);
            chk("t4_onebit", $countones(prev ^ cnt_gray), 1);
            prev = cnt_gray;
        end
        cnt_en = 1'b0;
        step();
        chk("t4_wrap_off", cnt_wrap, 0);

        // 5: down from zero, then clear over enable
        cnt_en = 1'b1; cnt_up = 1'b0;
        step();
        chk("t5_down_gray", cnt_gray, 4'b1000);
        chk("t5_down_wrap", cnt_wrap, 1);
        cnt_clr = 1'b1; cnt_up = 1'b1;
        step();
        chk("t5_clr_gray", cnt_gray, 0);
        chk("t5_clr_wrap", cnt_wrap, 0);
        cnt_clr = 1'b0; cnt_en = 1'b0;

        // 6: asynchronous reset with buffered data and running counter
        out_ready = 1'b0;
        cnt_en = 1'b1; cnt_up = 1'b1;
        in_valid = 1'b1; in_mode = 1'b0; in_data = 4'd1;
        step();
        in_data = 4'd2;
        step();
        in_valid = 1'b0;
        step();
        step();
        cnt_en = 1'b0;
        chk("t6_cnt_pre", cnt_gray, 4'b0110);
        chk("t6_full_pre", in_ready, 0);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_rst_valid", out_valid, 0);
        chk("t6_rst_gray", cnt_gray, 0);
        chk("t6_rst_wrap", cnt_wrap, 0);
        @(negedge clk) rst_n = 1'b1;
        #1 chk("t6_ready", in_ready, 1);
        step();
        out_ready = 1'b1;
        in_valid = 1'b1; in_mode = 1'b0; in_data = 4'b0101;
        step();
        in_valid = 1'b0;
        chk("t6_post_valid", out_valid, 1);
        chk("t6_post_data", out_data, 4'b0111);
        step();
        chk("t6_post_empty", out_valid, 0);
        step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
